cpu_control_unit: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 40 ++++
 rtl/alu_sel_decode.sv | 26 ++
 rtl/cpu_control_unit.sv | 124 ++++++++++++
 tb/tb_cpu_control_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and select codes for the
// ProjectB multi-cycle control unit.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ALU    = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5,
    OP_XOR   = 4'h6,
    OP_OR    = 4'h7,
    OP_AND   = 4'h8,
    OP_INC   = 4'h9,
    OP_MOV   = 4'hA
  } opcode_t;

  localparam logic [2:0] ALU_ZERO = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_AND  = 3'd6;
  localparam logic [2:0] ALU_INC  = 3'd7;

endpackage

// File: rtl/alu_sel_decode.sv
// Opcode to ALU function select map,
// plus a flag marking ALU-class opcodes.
module alu_sel_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output logic [2:0] alu_s,
  output logic       is_alu
);

  always_comb begin
    alu_s  = ALU_ZERO;
    is_alu = 1'b1;
    case (op)
      OP_ADD: alu_s = ALU_ADD;
      OP_SUB: alu_s = ALU_SUB;
      OP_XOR: alu_s = ALU_XOR;
      OP_OR:  alu_s = ALU_OR;
      OP_AND: alu_s = ALU_AND;
      OP_INC: alu_s = ALU_INC;
      OP_MOV: alu_s = ALU_PASS;
      default: is_alu = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle Moore control FSM: fetch,
// decode, and execute for ProjectB.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int RW = 4
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic [DW-1:0] Instr,
  output logic          PC_clr,
  output logic          PC_up,
  output logic          IR_ld,
  output logic [AW-1:0] D_addr,
  output logic          D_wr,
  output logic          RF_s,
  output logic [RW-1:0] RF_W_addr,
  output logic          RF_W_en,
  output logic [RW-1:0] RF_Ra_addr,
  output logic [RW-1:0] RF_Rb_addr,
  output logic [2:0]    ALU_s,
  output logic          Illegal,
  output logic [3:0]    StateOut
);

  state_t        state;
  state_t        next;
  logic [DW-1:0] ir;
  logic [3:0]    op;
  logic [2:0]    dec_s;
  logic          dec_alu;

  assign op = ir[15:12];

  alu_sel_decode u_dec (
    .op     (op),
    .alu_s  (dec_s),
    .is_alu (dec_alu)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= S_INIT;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == S_FETCH) ir <= Instr;
    end
  end

  always_comb begin
    next       = state;
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s      = ALU_ZERO;
    Illegal    = 1'b0;
    StateOut   = state;
    unique case (state)
      S_INIT: begin
        PC_clr = 1'b1;
        next   = S_FETCH;
      end
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
        next  = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          op == OP_NOOP:  next = S_NOOP;
          op == OP_STORE: next = S_STORE;
          op == OP_LOAD:  next = S_LOAD_A;
          op == OP_HALT:  next = S_HALT;
          dec_alu:        next = S_ALU;
          default: begin
            next    = S_NOOP;
            Illegal = 1'b1;
          end
        endcase
      end
      S_NOOP: next = S_FETCH;
      S_LOAD_A: begin
        D_addr    = AW'(ir[11:4]);
        RF_s      = 1'b1;
        RF_W_addr = RW'(ir[3:0]);
        next      = S_LOAD_B;
      end
      S_LOAD_B: begin
        D_addr    = AW'(ir[11:4]);
        RF_s      = 1'b1;
        RF_W_addr = RW'(ir[3:0]);
        RF_W_en   = 1'b1;
        next      = S_FETCH;
      end
      S_STORE: begin
        D_addr     = AW'(ir[7:0]);
        RF_Ra_addr = RW'(ir[11:8]);
        D_wr       = 1'b1;
        next       = S_FETCH;
      end
      S_ALU: begin
        RF_Ra_addr = RW'(ir[11:8]);
        RF_Rb_addr = RW'(ir[7:4]);
        RF_W_addr  = RW'(ir[3:0]);
        RF_W_en    = 1'b1;
        ALU_s      = dec_s;
        next       = S_FETCH;
      end
      S_HALT: next = S_HALT;
      default: next = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed-vector bench for the
// ProjectB control unit.
module tb_cpu_control_unit;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic [15:0] Instr = '0;
  logic        PC_clr, PC_up, IR_ld, D_wr;
  logic        RF_s, RF_W_en, Illegal;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [2:0]  ALU_s;
  logic [3:0]  StateOut;

  int pass_cnt = 0;
  int total_cnt = 0;

  cpu_control_unit #(.DW(16), .AW(8), .RW(4)) dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .Instr      (Instr),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s      (ALU_s),
    .Illegal    (Illegal),
    .StateOut   (StateOut)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    repeat (3) @(negedge Clk);
    total_cnt++;
    if (StateOut !== 4'd0) $display("FAIL rst_state got %0d want 0", StateOut);
    else pass_cnt++;
    total_cnt++;
    if ({PC_clr, PC_up, IR_ld, D_wr, RF_W_en, Illegal} !== 6'b100000)
      $display("FAIL rst_outs got %b want 100000",
               {PC_clr, PC_up, IR_ld, D_wr, RF_W_en, Illegal});
    else pass_cnt++;
    ResetN = 1'b1;
    step();
    total_cnt++;
    if (StateOut !== 4'd1 || IR_ld !== 1'b1 || PC_up !== 1'b1)
      $display("FAIL rst_fetch got st=%0d ld=%b up=%b want 1 1 1",
               StateOut, IR_ld, PC_up);
    else pass_cnt++;
  endtask

  task automatic test_load();
    Instr = 16'h21B5;
    step();
    total_cnt++;
    if (StateOut !== 4'd2) $display("FAIL ld_decode got %0d want 2", StateOut);
    else pass_cnt++;
    step();
    total_cnt++;
    if (StateOut !== 4'd4 || D_addr !== 8'h1B || RF_s !== 1'b1 || RF_W_en !== 1'b0)
      $display("FAIL ld_a got st=%0d a=%h s=%b en=%b want 4 1b 1 0",
               StateOut, D_addr, RF_s, RF_W_en);
    else pass_cnt++;
    step();
    total_cnt++;
    if (StateOut !== 4'd5 || D_addr !== 8'h1B || RF_s !== 1'b1 ||
        RF_W_addr !== 4'd5 || RF_W_en !== 1'b1)
      $display("FAIL ld_b got st=%0d a=%h s=%b wa=%0d en=%b want 5 1b 1 5 1",
               StateOut, D_addr, RF_s, RF_W_addr, RF_W_en);
    else pass_cnt++;
    step();
    total_cnt++;
    if (StateOut !== 4'd1 || RF_W_en !== 1'b0)
      $display("FAIL ld_done got st=%0d en=%b want 1 0", StateOut, RF_W_en);
    else pass_cnt++;
  endtask

  task automatic test_alu_ops();
    logic [3:0] ops [7] = '{4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    logic [2:0] sel [7] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
    for (int i = 0; i < 7; i++) begin
      Instr = {ops[i], 4'h2, 4'h1, 4'h4};
      step();
      total_cnt++;
      if (ALU_s !== 3'd0 || RF_W_en !== 1'b0)
        $display("FAIL alu_dec op=%h got s=%0d en=%b want 0 0",
                 ops[i], ALU_s, RF_W_en);
      else pass_cnt++;
      step();
      total_cnt++;
      if (StateOut !== 4'd7 || RF_Ra_addr !== 4'd2 || RF_Rb_addr !== 4'd1 ||
          RF_W_addr !== 4'd4 || RF_W_en !== 1'b1 || RF_s !== 1'b0 ||
          ALU_s !== sel[i])
        $display("FAIL alu_exec op=%h got st=%0d ra=%0d rb=%0d wa=%0d en=%b s=%0d want 7 2 1 4 1 %0d",
                 ops[i], StateOut, RF_Ra_addr, RF_Rb_addr, RF_W_addr,
                 RF_W_en, ALU_s, sel[i]);
      else pass_cnt++;
      step();
      total_cnt++;
      if (StateOut !== 4'd1 || ALU_s !== 3'd0)
        $display("FAIL alu_back op=%h got st=%0d s=%0d want 1 0",
                 ops[i], StateOut, ALU_s);
      else pass_cnt++;
    end
  endtask

  task automatic test_store();
    int wr_cycles = 0;
    Instr = 16'h173C;
    step();
    if (D_wr === 1'b1) wr_cycles++;
    step();
    if (D_wr === 1'b1) wr_cycles++;
    total_cnt++;
    if (StateOut !== 4'd6 || D_wr !== 1'b1 || D_addr !== 8'h3C || RF_Ra_addr !== 4'd7)
      $display("FAIL st_exec got st=%0d wr=%b a=%h ra=%0d want 6 1 3c 7",
               StateOut, D_wr, D_addr, RF_Ra_addr);
    else pass_cnt++;
    step();
    if (D_wr === 1'b1) wr_cycles++;
    total_cnt++;
    if (StateOut !== 4'd1 || wr_cycles != 1)
      $display("FAIL st_done got st=%0d wr_cycles=%0d want 1 1", StateOut, wr_cycles);
    else pass_cnt++;
  endtask

  task automatic test_illegal_halt();
    Instr = 16'hF000;
    step();
    total_cnt++;
    if (StateOut !== 4'd2 || Illegal !== 1'b1)
      $display("FAIL ill_dec got st=%0d ill=%b want 2 1", StateOut, Illegal);
    else pass_cnt++;
    step();
    total_cnt++;
    if (StateOut !== 4'd3 || Illegal !== 1'b0 || D_wr !== 1'b0 || RF_W_en !== 1'b0)
      $display("FAIL ill_noop got st=%0d ill=%b wr=%b en=%b want 3 0 0 0",
               StateOut, Illegal, D_wr, RF_W_en);
    else pass_cnt++;
    step();
    total_cnt++;
    if (StateOut !== 4'd1) $display("FAIL ill_back got %0d want 1", StateOut);
    else pass_cnt++;
    Instr = 16'h5000;
    step();
    step();
    for (int i = 0; i < 20; i++) begin
      total_cnt++;
      if (StateOut !== 4'd8 || PC_up !== 1'b0 || D_wr !== 1'b0 || RF_W_en !== 1'b0)
        $display("FAIL halt_hold cyc=%0d got st=%0d up=%b wr=%b en=%b want 8 0 0 0",
                 i, StateOut, PC_up, D_wr, RF_W_en);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_reset_mid_load();
    int en_seen = 0;
    test_reset();
    Instr = 16'h21B5;
    step();
    step();
    total_cnt++;
    if (StateOut !== 4'd4) $display("FAIL mid_la got %0d want 4", StateOut);
    else pass_cnt++;
    #2 ResetN = 1'b0;
    #1;
    total_cnt++;
    if (StateOut !== 4'd0 || PC_clr !== 1'b1 || RF_W_en !== 1'b0)
      $display("FAIL mid_rst got st=%0d clr=%b en=%b want 0 1 0",
               StateOut, PC_clr, RF_W_en);
    else pass_cnt++;
    repeat (3) begin
      @(posedge Clk);
      #1 if (RF_W_en === 1'b1) en_seen++;
    end
    @(negedge Clk);
    ResetN = 1'b1;
    total_cnt++;
    if (StateOut !== 4'd0 || PC_clr !== 1'b1)
      $display("FAIL mid_init got st=%0d clr=%b want 0 1", StateOut, PC_clr);
    else pass_cnt++;
    step();
    if (RF_W_en === 1'b1) en_seen++;
    total_cnt++;
    if (StateOut !== 4'd1 || en_seen != 0)
      $display("FAIL mid_restart got st=%0d en_seen=%0d want 1 0", StateOut, en_seen);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_alu_ops();
    test_store();
    test_illegal_halt();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
